bus_arbiter_2x4: RTL and testbench
==================================

Name: bus_arbiter_2x4

Overview:
Two-requester, round-robin arbiter that shares one 4-bit output bus between two sources. Each source has a valid/ready handshake. The arbiter computes the 2:1 select, registers the winning beat into a one-entry output stage, and tags the beat with its source id. A burst limit bounds how long one source can hold the bus while the other is waiting.

Parameters:
WIDTH, 4, data width of each input and of the output bus
BURST_MAX, 4, max consecutive beats granted to one source while the other is requesting (legal range 1..15)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_1  input  WIDTH  requester 1 data
in_1_valid  input  1  requester 1 has a beat
in_1_ready  output  1  requester 1 beat accepted this cycle (combinational)
in_2  input  WIDTH  requester 2 data
in_2_valid  input  1  requester 2 has a beat
in_2_ready  output  1  requester 2 beat accepted this cycle (combinational)
out_1  output  WIDTH  registered output data
out_valid  output  1  out_1 holds a beat
out_ready  input  1  downstream accepts beat
out_src  output  1  source of out_1: 0 = in_1, 1 = in_2

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_1=0, out_src=0
  - state=IDLE, beat_cnt=0, last_grant=2, so requester 1 wins the first contended arbitration
  - in_x_ready=0 while rst is high
- can_accept = !out_valid | out_ready. Output stage is one register; full throughput is one beat per cycle.
- States: IDLE, GNT1, GNT2. sel is combinational from state, valids and beat_cnt.
  - IDLE:
    - only one valid: sel that one
    - both valid: sel the source != last_grant
    - none valid: no sel
  - GNTx, keep x if in_x_valid and (other not valid or beat_cnt < BURST_MAX).
  - GNTx, otherwise:
    - switch to the other source if it is valid
    - else go to IDLE with no sel
- in_x_ready = can_accept & sel==x & !rst. A transfer happens when in_x_valid & in_x_ready.
- On a transfer from x:
  - out_1 <= in_x, out_src <= x-1, out_valid <= 1
  - state <= GNTx, last_grant <= x
  - beat_cnt <= beat_cnt+1 if x equals the previous grant, else 1. beat_cnt saturates at 15.
- No transfer, but out_valid & out_ready: out_valid <= 0. out_1 and out_src hold their last values.
- No transfer and no sel: state <= IDLE, beat_cnt <= 0. last_grant is kept.
- Stall (out_valid & !out_ready):
  - no ready asserted
  - state, beat_cnt and the output register frozen
  - valids may toggle without effect
- Latency: input beat appears on out_1 the cycle after its transfer. Zero bubbles between back-to-back beats when out_ready is held high.
- Data ordering within one source is preserved. Beats are never dropped or duplicated.
- Invariant: in_1_ready & in_2_ready is never 1.

Test Plan:
- Reset then single source: rst pulse; in_1=4'hA valid for 3 cycles, out_ready=1 → out_1=A, out_src=0 on cycles 1-3 after each accept; in_2_ready=0 throughout.
- First contention: both valid at first cycle after reset, in_1=4'h3, in_2=4'hC → requester 1 granted first (out_src=0, out_1=3).
- Burst limit, BURST_MAX=4: both valid continuously, out_ready=1 → out_src sequence 0,0,0,0,1,1,1,1,0…
- Burst limit with idle other: in_2 idle → in_1 granted every cycle past 4 beats without a switch.
- Backpressure: out_ready=0 with out_valid=1 for 5 cycles while both valid → out_1, out_src, state and beat_cnt unchanged; both ready=0. On release, the stalled beat is consumed and the next beat is accepted the same cycle (one-per-cycle throughput).
- Reset mid-burst: assert rst asynchronously during a GNT2 burst at beat_cnt=2 with out_valid=1 → out_valid drops immediately (no clock edge needed), ready=0. After release with both valid, requester 1 wins.
- Scoreboard: random valid/ready over 2000 cycles → per-source ordering intact, no loss or duplication, never both readys high, no source waits more than BURST_MAX accepted beats of the other.

Source files
------------

// File: rtl/bus_arbiter_2x4.sv
// Two-requester round-robin arbiter feeding a one-entry registered output stage.
// Each beat is tagged with its source id; BURST_MAX bounds one source's hold while the other waits.
module bus_arbiter_2x4 #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_1,
    input  logic             in_1_valid,
    output logic             in_1_ready,
    input  logic [WIDTH-1:0] in_2,
    input  logic             in_2_valid,
    output logic             in_2_ready,
    output logic [WIDTH-1:0] out_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src
);

    typedef enum logic [1:0] {IDLE, GNT1, GNT2} state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    state_t     state, state_next;
    logic [3:0] beat_cnt, cnt_next, cnt_inc;
    logic       last_grant, last_next;   // 0: in_1, 1: in_2
    logic       sel1, sel2;
    logic       can_accept, burst_ok;
    logic       xfer1, xfer2;

    assign can_accept = !out_valid | out_ready;
    assign burst_ok   = beat_cnt < BURST_LIM;
    assign cnt_inc    = (beat_cnt == 4'hF) ? 4'hF : beat_cnt + 4'd1;

    assign in_1_ready = can_accept & sel1 & !rst;
    assign in_2_ready = can_accept & sel2 & !rst;
    assign xfer1      = in_1_valid & in_1_ready;
    assign xfer2      = in_2_valid & in_2_ready;

    always_comb begin
        sel1 = 1'b0;
        sel2 = 1'b0;
        case (state)
            IDLE: begin
                if (in_1_valid && in_2_valid) begin
                    sel1 = last_grant;
                    sel2 = !last_grant;
                end else begin
                    sel1 = in_1_valid;
                    sel2 = in_2_valid;
                end
            end
            GNT1: begin
                if (in_1_valid && (!in_2_valid || burst_ok)) sel1 = 1'b1;
                else                                         sel2 = in_2_valid;
            end
            GNT2: begin
                if (in_2_valid && (!in_1_valid || burst_ok)) sel2 = 1'b1;
                else                                         sel1 = in_1_valid;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = beat_cnt;
        last_next  = last_grant;
        if (xfer1) begin
            state_next = GNT1;
            last_next  = 1'b0;
            cnt_next   = (last_grant == 1'b0) ? cnt_inc : 4'd1;
        end else if (xfer2) begin
            state_next = GNT2;
            last_next  = 1'b1;
            cnt_next   = (last_grant == 1'b1) ? cnt_inc : 4'd1;
        end else if (can_accept) begin
            // Every sel is gated by its valid, so accepting with no transfer means nothing was selected.
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            beat_cnt   <= cnt_next;
            last_grant <= last_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_1     <= '0;
            out_src   <= 1'b0;
        end else if (xfer1) begin
            out_valid <= 1'b1;
            out_1     <= in_1;
            out_src   <= 1'b0;
        end else if (xfer2) begin
            out_valid <= 1'b1;
            out_1     <= in_2;
            out_src   <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2x4.sv
// Directed and randomized checks for bus_arbiter_2x4: reset, grants, burst limit,
// backpressure, asynchronous reset, and a scoreboard over random valid/ready traffic.
module tb_bus_arbiter_2x4;

    localparam int BURST_MAX = 4;

    logic       clk;
    logic       rst;
    logic [3:0] in_1, in_2, out_1;
    logic       in_1_valid, in_2_valid, in_1_ready, in_2_ready;
    logic       out_valid, out_ready, out_src;

    int checks   = 0;
    int failures = 0;

    logic       a1, a2;
    logic [4:0] exp_beat;
    logic [4:0] sbq[$];
    logic [3:0] seq1, seq2;
    logic [8:0] exp_seq;
    logic [3:0] exp_data;
    int         wait1, wait2;

    bus_arbiter_2x4 #(.WIDTH(4), .BURST_MAX(BURST_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_1      (in_1),
        .in_1_valid(in_1_valid),
        .in_1_ready(in_1_ready),
        .in_2      (in_2),
        .in_2_valid(in_2_valid),
        .in_2_ready(in_2_ready),
        .out_1     (out_1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic [3:0] d1,
                         input logic v2, input logic [3:0] d2, input logic ordy);
        in_1_valid = v1;
        in_1       = d1;
        in_2_valid = v2;
        in_2       = d2;
        out_ready  = ordy;
    endtask

    task automatic check_out(input string tag, input logic src, input logic [3:0] data);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_src"},   32'(out_src),   32'(src));
        check({tag, "_data"},  32'(out_1),     32'(data));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_1",     32'(out_1),     32'd0);
        check("rst_out_src",   32'(out_src),   32'd0);
        in_1_valid = 1'b1;
        in_2_valid = 1'b1;
        #1;
        check("rst_ready1", 32'(in_1_ready), 32'd0);
        check("rst_ready2", 32'(in_2_ready), 32'd0);

        // single source
        tick();
        rst = 1'b0;
        drive(1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
        #1;
        check("single_ready1", 32'(in_1_ready), 32'd1);
        check("single_ready2", 32'(in_2_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("single", 1'b0, 4'hA);
            check("single_ready2_hold", 32'(in_2_ready), 32'd0);
        end
        in_1_valid = 1'b0;
        tick();
        check("single_drain_valid", 32'(out_valid), 32'd0);
        check("single_drain_hold",  32'(out_1),     32'hA);

        // first contention after reset, then burst alternation
        rst = 1'b1;
        #1;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        drive(1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
        #1;
        check("contend_ready1", 32'(in_1_ready), 32'd1);
        check("contend_ready2", 32'(in_2_ready), 32'd0);
        exp_seq = 9'b0_1111_0000;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_data = exp_seq[i] ? 4'hC : 4'h3;
            check_out("burst", exp_seq[i], exp_data);
        end

        // backpressure: everything frozen for 5 cycles
        drive(1'b1, 4'h5, 1'b1, 4'hC, 1'b0);
        #1;
        check("stall_ready1", 32'(in_1_ready), 32'd0);
        check("stall_ready2", 32'(in_2_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("stall", 1'b0, 4'h3);
            check("stall_ready1_hold", 32'(in_1_ready), 32'd0);
            check("stall_ready2_hold", 32'(in_2_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready1", 32'(in_1_ready), 32'd1);
        check("release_ready2", 32'(in_2_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("release", 1'b0, 4'h5);
        end
        tick();
        check_out("release_switch", 1'b1, 4'hC);

        // burst limit does not apply when the other side is idle
        drive(1'b1, 4'h7, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_out("solo", 1'b0, 4'h7);
            check("solo_ready1", 32'(in_1_ready), 32'd1);
        end

        // asynchronous reset in the middle of a GNT2 burst
        drive(1'b0, 4'h0, 1'b1, 4'h9, 1'b1);
        tick();
        check_out("gnt2_b1", 1'b1, 4'h9);
        tick();
        check_out("gnt2_b2", 1'b1, 4'h9);
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid),  32'd0);
        check("arst_out_1",     32'(out_1),      32'd0);
        check("arst_out_src",   32'(out_src),    32'd0);
        check("arst_ready2",    32'(in_2_ready), 32'd0);
        drive(1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
        #1;
        check("arst_hold_ready1", 32'(in_1_ready), 32'd0);
        check("arst_hold_ready2", 32'(in_2_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("arst_rel_ready1", 32'(in_1_ready), 32'd1);
        check("arst_rel_ready2", 32'(in_2_ready), 32'd0);
        tick();
        check_out("arst_first", 1'b0, 4'h3);
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        check("pre_random_empty", 32'(out_valid), 32'd0);

        // random traffic against a scoreboard in acceptance order
        seq1  = 4'h0;
        seq2  = 4'h8;
        wait1 = 0;
        wait2 = 0;
        for (int cyc = 0; cyc < 2010; cyc++) begin
            if (cyc >= 2000) begin
                in_1_valid = 1'b0;
                in_2_valid = 1'b0;
                out_ready  = 1'b1;
            end
            @(negedge clk);
            check("both_ready", 32'(in_1_ready & in_2_ready), 32'd0);
            a1 = in_1_valid & in_1_ready;
            a2 = in_2_valid & in_2_ready;
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    exp_beat = sbq.pop_front();
                    check("sb_beat", 32'({out_src, out_1}), 32'(exp_beat));
                end
            end
            if (a1) sbq.push_back({1'b0, in_1});
            if (a2) sbq.push_back({1'b1, in_2});
            if (a1) wait1 = 0;
            else if (in_1_valid && a2) begin
                wait1++;
                check("wait1_bound", 32'(wait1 <= BURST_MAX), 32'd1);
            end
            if (a2) wait2 = 0;
            else if (in_2_valid && a1) begin
                wait2++;
                check("wait2_bound", 32'(wait2 <= BURST_MAX), 32'd1);
            end
            tick();
            if (cyc < 2000) begin
                if (a1 || !in_1_valid) begin
                    in_1_valid = ($urandom_range(0, 3) != 0);
                    if (in_1_valid) begin
                        seq1 = seq1 + 4'd1;
                        in_1 = seq1;
                    end
                end
                if (a2 || !in_2_valid) begin
                    in_2_valid = ($urandom_range(0, 3) != 0);
                    if (in_2_valid) begin
                        seq2 = seq2 + 4'd1;
                        in_2 = seq2;
                    end
                end
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        check("sb_drained", 32'(sbq.size()), 32'd0);
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
